// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU results through and runs loads/stores on the data bus.
// Each access walks IDLE -> REQ -> DONE; a missing ack aborts it after TIMEOUT cycles.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_in,
   input  logic [15:0] inst,
   input  logic [15:0] alu_res,
   input  logic [15:0] store_data,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        wr_en,
   input  logic [2:0]  write_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic [15:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [15:0] inst_out,
   output logic [15:0] res_out,
   output logic        wr_en_out,
   output logic [2:0]  write_addr_out,
   output logic        stall,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nx;
   logic [7:0]  cnt;
   logic [15:0] l_inst;
   logic [15:0] l_addr;
   logic [15:0] l_wdata;
   logic [15:0] l_rdata;
   logic        l_we;
   logic        l_wr_en;
   logic [2:0]  l_waddr;
   logic        aborted;
   logic        mem_op;

   assign mem_op = valid_in & (mem_rd | mem_wr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         l_inst  <= '0;
         l_addr  <= '0;
         l_wdata <= '0;
         l_rdata <= '0;
         l_we    <= 1'b0;
         l_wr_en <= 1'b0;
         l_waddr <= '0;
         aborted <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               cnt     <= '0;
               aborted <= 1'b0;
               if (mem_op) begin
                  l_inst  <= inst;
                  l_addr  <= alu_res;
                  l_wdata <= store_data;
                  // a combined rd+wr request is a store
                  l_we    <= mem_wr;
                  l_wr_en <= wr_en;
                  l_waddr <= write_addr;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  l_rdata <= dmem_rdata;
                  cnt     <= '0;
               end else if (cnt == LAST) begin
                  aborted <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (mem_op) state_nx = REQ;
         REQ:     if (dmem_ack || cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      inst_out       = '0;
      res_out        = '0;
      wr_en_out      = 1'b0;
      write_addr_out = '0;
      stall          = 1'b0;
      bus_err        = 1'b0;
      unique case (state)
         IDLE: begin
            stall = mem_op;
            if (valid_in && !(mem_rd || mem_wr)) begin
               inst_out       = inst;
               res_out        = alu_res;
               wr_en_out      = wr_en;
               write_addr_out = write_addr;
            end
         end
         REQ: begin
            dmem_req   = 1'b1;
            dmem_we    = l_we;
            dmem_addr  = l_addr;
            dmem_wdata = l_wdata;
            stall      = 1'b1;
         end
         DONE: begin
            inst_out       = l_inst;
            write_addr_out = l_waddr;
            if (aborted) begin
               bus_err = 1'b1;
            end else if (l_we) begin
               res_out = l_addr;
            end else begin
               res_out   = l_rdata;
               wr_en_out = l_wr_en;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed per-cycle vectors for mem_access_stage.
// Inputs applied on negedge, outputs compared 1ns later.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [15:0] inst;
   logic [15:0] alu_res;
   logic [15:0] store_data;
   logic        mem_rd;
   logic        mem_wr;
   logic        wr_en;
   logic [2:0]  write_addr;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ack;
   logic [15:0] inst_out;
   logic [15:0] res_out;
   logic        wr_en_out;
   logic [2:0]  write_addr_out;
   logic        stall;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(15)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .valid_in(valid_in),
      .inst(inst),
      .alu_res(alu_res),
      .store_data(store_data),
      .mem_rd(mem_rd),
      .mem_wr(mem_wr),
      .wr_en(wr_en),
      .write_addr(write_addr),
      .dmem_req(dmem_req),
      .dmem_we(dmem_we),
      .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack),
      .inst_out(inst_out),
      .res_out(res_out),
      .wr_en_out(wr_en_out),
      .write_addr_out(write_addr_out),
      .stall(stall),
      .bus_err(bus_err)
   );

   typedef struct packed {
      logic        rst_n;
      logic        valid;
      logic        rd;
      logic        wr;
      logic        wen;
      logic        ack;
      logic [15:0] inst;
      logic [15:0] alu;
      logic [15:0] sd;
      logic [15:0] rdata;
      logic [2:0]  wa;
   } in_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] inst;
      logic [15:0] res;
      logic        wen;
      logic [2:0]  wa;
      logic        stall;
      logic        berr;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t tv[$];
   int   tests = 0;
   int   fails = 0;

   function automatic in_t mi(
      input logic v, input logic [15:0] in_inst, input logic [15:0] alu,
      input logic [15:0] sd, input logic rd, input logic wr,
      input logic wen, input logic [2:0] wa,
      input logic ack, input logic [15:0] rdata);
      in_t r;
      r.rst_n = 1'b1;
      r.valid = v;
      r.inst  = in_inst;
      r.alu   = alu;
      r.sd    = sd;
      r.rd    = rd;
      r.wr    = wr;
      r.wen   = wen;
      r.wa    = wa;
      r.ack   = ack;
      r.rdata = rdata;
      return r;
   endfunction

   function automatic out_t mo(
      input logic req, input logic we, input logic [15:0] addr,
      input logic [15:0] wdata, input logic [15:0] o_inst,
      input logic [15:0] res, input logic wen, input logic [2:0] wa,
      input logic stl, input logic berr);
      out_t r;
      r.req   = req;
      r.we    = we;
      r.addr  = addr;
      r.wdata = wdata;
      r.inst  = o_inst;
      r.res   = res;
      r.wen   = wen;
      r.wa    = wa;
      r.stall = stl;
      r.berr  = berr;
      return r;
   endfunction

   task automatic run(input vec_t t, input string name);
      out_t got;
      @(negedge clk);
      rst_n      = t.i.rst_n;
      valid_in   = t.i.valid;
      inst       = t.i.inst;
      alu_res    = t.i.alu;
      store_data = t.i.sd;
      mem_rd     = t.i.rd;
      mem_wr     = t.i.wr;
      wr_en      = t.i.wen;
      write_addr = t.i.wa;
      dmem_ack   = t.i.ack;
      dmem_rdata = t.i.rdata;
      #1;
      got = mo(dmem_req, dmem_we, dmem_addr, dmem_wdata, inst_out,
               res_out, wr_en_out, write_addr_out, stall, bus_err);
      tests++;
      if (got !== t.o) begin
         fails++;
         $display("FAIL %s: got req=%b we=%b addr=%h wd=%h inst=%h res=%h wen=%b wa=%0d stall=%b berr=%b, want req=%b we=%b addr=%h wd=%h inst=%h res=%h wen=%b wa=%0d stall=%b berr=%b",
                  name, got.req, got.we, got.addr, got.wdata, got.inst,
                  got.res, got.wen, got.wa, got.stall, got.berr,
                  t.o.req, t.o.we, t.o.addr, t.o.wdata, t.o.inst,
                  t.o.res, t.o.wen, t.o.wa, t.o.stall, t.o.berr);
      end
   endtask

   initial begin
      out_t zo;
      out_t bub;
      in_t  ld;
      in_t  idle;
      vec_t v;

      zo   = mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bub  = mo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ALU pass-through, then idle with junk on the bus
      tv.push_back('{mi(1, 16'h0101, 16'h1234, 0, 0, 0, 1, 3, 0, 0),
                     mo(0, 0, 0, 0, 16'h0101, 16'h1234, 1, 3, 0, 0)});
      tv.push_back('{mi(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 1, 7, 0, 0), zo});
      // load 0040, ack on third REQ cycle
      ld = mi(1, 16'h2202, 16'h0040, 16'h1111, 1, 0, 1, 5, 0, 0);
      tv.push_back('{ld, bub});
      tv.push_back('{ld, mo(1, 0, 16'h0040, 16'h1111, 0, 0, 0, 0, 1, 0)});
      tv.push_back('{ld, mo(1, 0, 16'h0040, 16'h1111, 0, 0, 0, 0, 1, 0)});
      ld.ack = 1'b1;
      ld.rdata = 16'hBEEF;
      tv.push_back('{ld, mo(1, 0, 16'h0040, 16'h1111, 0, 0, 0, 0, 1, 0)});
      ld.rdata = 16'h0000;
      tv.push_back('{ld, mo(0, 0, 0, 0, 16'h2202, 16'hBEEF, 1, 5, 0, 0)});
      // store A5A5 to 0010, immediate ack
      ld = mi(1, 16'h3303, 16'h0010, 16'hA5A5, 0, 1, 0, 2, 0, 0);
      tv.push_back('{ld, bub});
      ld.ack = 1'b1;
      tv.push_back('{ld, mo(1, 1, 16'h0010, 16'hA5A5, 0, 0, 0, 0, 1, 0)});
      tv.push_back('{ld, mo(0, 0, 0, 0, 16'h3303, 16'h0010, 0, 2, 0, 0)});
      // rd and wr together behave as a store
      ld = mi(1, 16'h4404, 16'h0020, 16'h5A5A, 1, 1, 1, 6, 0, 0);
      tv.push_back('{ld, bub});
      ld.ack = 1'b1;
      ld.rdata = 16'h9999;
      tv.push_back('{ld, mo(1, 1, 16'h0020, 16'h5A5A, 0, 0, 0, 0, 1, 0)});
      tv.push_back('{ld, mo(0, 0, 0, 0, 16'h4404, 16'h0020, 0, 6, 0, 0)});
      // load then ALU op back to back
      ld = mi(1, 16'h5505, 16'h0080, 0, 1, 0, 1, 1, 0, 0);
      tv.push_back('{ld, bub});
      ld.ack = 1'b1;
      ld.rdata = 16'hCAFE;
      tv.push_back('{ld, mo(1, 0, 16'h0080, 0, 0, 0, 0, 0, 1, 0)});
      ld = mi(1, 16'h6606, 16'h7777, 0, 0, 0, 1, 4, 1, 16'h0BAD);
      tv.push_back('{ld, mo(0, 0, 0, 0, 16'h5505, 16'hCAFE, 1, 1, 0, 0)});
      tv.push_back('{ld, mo(0, 0, 0, 0, 16'h6606, 16'h7777, 1, 4, 0, 0)});
      // stray ack while idle
      tv.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h1234), zo});
      // reset in the second REQ cycle abandons the load
      ld = mi(1, 16'h7707, 16'h00A0, 0, 1, 0, 1, 2, 0, 0);
      tv.push_back('{ld, bub});
      tv.push_back('{ld, mo(1, 0, 16'h00A0, 0, 0, 0, 0, 0, 1, 0)});
      ld.rst_n = 1'b0;
      tv.push_back('{ld, mo(1, 0, 16'h00A0, 0, 0, 0, 0, 0, 1, 0)});
      tv.push_back('{mi(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD), zo});
      tv.push_back('{idle, zo});

      rst_n      = 1'b0;
      valid_in   = 1'b0;
      inst       = '0;
      alu_res    = '0;
      store_data = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      wr_en      = 1'b0;
      write_addr = '0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      repeat (2) @(posedge clk);
      v.i = idle;
      v.i.rst_n = 1'b0;
      v.o = zo;
      run(v, "reset");

      for (int k = 0; k < tv.size(); k++)
         run(tv[k], $sformatf("vec%0d", k));

      // timeout: 15 REQ cycles, then aborted DONE with bus_err
      v.i = mi(1, 16'h8808, 16'h00C0, 0, 1, 0, 1, 7, 0, 0);
      v.o = bub;
      run(v, "tmo_accept");
      v.o = mo(1, 0, 16'h00C0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 15; k++)
         run(v, $sformatf("tmo_req%0d", k));
      v.o = mo(0, 0, 0, 0, 16'h8808, 0, 0, 7, 0, 1);
      run(v, "tmo_done");
      v.i = idle;
      v.o = zo;
      run(v, "tmo_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum number of REQ-state cycles without dmem_ack before the access is aborted (legal range 1..255).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 valid_in  in  1  EX/MEM slot holds a live instruction.
REQ-006 inst  in  16  instruction word from EX/MEM.
REQ-007 alu_res  in  16  ALU result; this is the memory address for loads and stores.
REQ-008 store_data  in  16  data to be written by a store.
REQ-009 mem_rd, mem_wr  in  1 each  load or store request.
REQ-010 wr_en  in  1  instruction writes the register file.
REQ-011 write_addr  in  3  destination register.
REQ-012 dmem_req, dmem_we  out  1 each  data-memory request and write strobe.
REQ-013 dmem_addr, dmem_wdata  out  16 each  memory address and write data.
REQ-014 dmem_rdata  in  16  read data; valid in the cycle dmem_ack=1.
REQ-015 dmem_ack  in  1  memory completion.
REQ-016 inst_out, res_out  out  16 each  instruction and result to MEM/WB.
REQ-017 wr_en_out  out  1  register write enable to MEM/WB.
REQ-018 write_addr_out  out  3  destination register to MEM/WB.
REQ-019 stall  out  1  upstream SHALL hold EX/MEM contents while stall=1.
REQ-020 bus_err  out  1  one-cycle pulse on access timeout.

Function
REQ-021 FSM states SHALL be IDLE, REQ and DONE.
REQ-022 IDLE, valid_in=1, mem_rd=mem_wr=0: outputs SHALL be a combinational pass-through (inst, alu_res, wr_en, write_addr) with stall=0 and no state change.
REQ-023 IDLE, valid_in=0: inst_out=0, res_out=0, wr_en_out=0, write_addr_out=0, stall=0.
REQ-024 IDLE, valid_in=1 with mem_rd or mem_wr: stall SHALL be 1 combinationally and outputs SHALL show a bubble (all zero); at the clock edge the block latches inst, alu_res, store_data, mem_wr, mem_rd, wr_en and write_addr, then enters REQ.
REQ-025 If mem_rd=1 and mem_wr=1, the access SHALL be treated as a store.
REQ-026 REQ: dmem_req=1, dmem_addr=latched alu_res, dmem_we=latched mem_wr, dmem_wdata=latched store_data, stall=1, outputs bubble; the block holds these values until dmem_ack.
REQ-027 REQ with dmem_ack=1: latch dmem_rdata (load), clear timeout counter, enter DONE; dmem_req SHALL be 0 from the next cycle.
REQ-028 The timeout counter (8 bits) SHALL increment each REQ cycle without ack; when it reaches TIMEOUT-1 without ack, the block enters DONE with an aborted flag, drops dmem_req, and pulses bus_err=1 in the DONE cycle.
REQ-029 DONE, stall=0, and outputs show the latched instruction:
- load: res_out=read data, wr_en_out=latched wr_en.
- store: res_out=latched alu_res, wr_en_out=0.
- aborted: res_out=0, wr_en_out=0.
DONE SHALL always return to IDLE.
REQ-030 In DONE, valid_in and the input bus SHALL be ignored, because they still carry the completed instruction.
REQ-031 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-032 Latency with ack in the first REQ cycle: accept at T, REQ at T+1, DONE at T+2; stall=1 at T and T+1.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, clear the counter, the latches and the aborted flag, and drive dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, bus_err=0 and stall=0 from that edge.
REQ-034 Reset asserted in REQ or DONE SHALL abandon the access with no MEM/WB write-back.

Verification
REQ-035 ALU op: valid_in=1, alu_res=16'h1234, wr_en=1, write_addr=3 -> same cycle res_out=16'h1234, wr_en_out=1, write_addr_out=3, stall=0.
REQ-036 Load from 16'h0040 with ack on the 3rd REQ cycle returning 16'hBEEF -> stall high for 4 cycles; DONE gives res_out=16'hBEEF, wr_en_out=1; dmem_we=0 throughout.
REQ-037 Store of 16'hA5A5 to 16'h0010 with immediate ack -> dmem_we=1, dmem_wdata=16'hA5A5 for 1 cycle; DONE gives wr_en_out=0.
REQ-038 Load with ack never asserted, TIMEOUT=15 -> dmem_req held 15 cycles then dropped; bus_err=1 for one cycle; res_out=0, wr_en_out=0.
REQ-039 rst_n=0 in the 2nd REQ cycle -> next cycle dmem_req=0, stall=0, all outputs 0; a later ack causes no write-back.
REQ-040 Back-to-back load then ALU op -> ALU op outputs appear the cycle after DONE, with no duplicate of the load.
